// File: rtl/decoder_2bit_to_ascii_tx.sv
// decoder_2bit_to_ascii_tx: buffers 2-bit symbols in a FIFO and emits ASCII digits '0'-'3' through a registered valid/ready port.
// Define NEWLINE_EN to insert a line feed (7'h0A) after every GROUP_LEN digits.
module decoder_2bit_to_ascii_tx #(
  parameter int DEPTH     = 4,
  parameter int GROUP_LEN = 8
) (
  input  logic                     i_clock,
  input  logic                     i_reset_n,
  input  logic                     i_flush,
  input  logic [1:0]               i_sym_in,
  input  logic                     i_sym_valid,
  output logic                     o_sym_ready,
  output logic [6:0]               o_ascii_out,
  output logic                     o_ascii_valid,
  input  logic                     i_ascii_ready,
  output logic [$clog2(DEPTH):0]   o_level
);
  localparam int AW = $clog2(DEPTH);
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || GROUP_LEN < 1 || GROUP_LEN > 255) begin : g_bad_cfg
    $error("decoder_2bit_to_ascii_tx: DEPTH must be a power of two >= 2, GROUP_LEN in 1..255");
  end
  typedef enum logic [1:0] {ST_IDLE, ST_CHAR, ST_NL} state_t;
  state_t     r_state, w_state_nxt;
  logic [1:0] r_mem [DEPTH];
  logic [AW:0] r_wr_ptr, r_rd_ptr, r_level;
  logic [6:0] r_ascii, w_ascii_nxt;
  logic       r_valid;
  logic       w_full, w_empty, w_push, w_pop, w_load;
`ifdef NEWLINE_EN
  logic [7:0] r_grp_cnt, w_grp_nxt;
`endif
  // Full/empty come only from registered pointers, so a same-cycle pop never frees a slot.
  assign w_empty = r_wr_ptr == r_rd_ptr;
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_push  = i_sym_valid && !w_full && !i_flush;
  assign w_load  = (r_state == ST_IDLE) || i_ascii_ready;
  assign o_sym_ready   = !w_full;
  assign o_ascii_out   = r_ascii;
  assign o_ascii_valid = r_valid;
  assign o_level       = r_level;
  always_comb begin
    w_state_nxt = r_state;
    w_ascii_nxt = r_ascii;
    w_pop       = 1'b0;
`ifdef NEWLINE_EN
    w_grp_nxt   = r_grp_cnt;
`endif
    if (w_load) begin
`ifdef NEWLINE_EN
      if (r_grp_cnt == 8'(GROUP_LEN)) begin
        w_state_nxt = ST_NL;
        w_ascii_nxt = 7'h0A;
        w_grp_nxt   = '0;
      end else
`endif
      if (!w_empty) begin
        w_state_nxt = ST_CHAR;
        w_ascii_nxt = {5'b01100, r_mem[r_rd_ptr[AW-1:0]]};
        w_pop       = 1'b1;
`ifdef NEWLINE_EN
        w_grp_nxt   = r_grp_cnt + 8'd1;
`endif
      end else begin
        w_state_nxt = ST_IDLE;
      end
    end
  end
  always_ff @(posedge i_clock) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_sym_in;
  end
  // Flush wins over any push, pop or output hand-off in the same cycle.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state   <= ST_IDLE;
      r_valid   <= 1'b0;
      r_ascii   <= 7'h00;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_level   <= '0;
`ifdef NEWLINE_EN
      r_grp_cnt <= '0;
`endif
    end else if (i_flush) begin
      r_state   <= ST_IDLE;
      r_valid   <= 1'b0;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_level   <= '0;
`ifdef NEWLINE_EN
      r_grp_cnt <= '0;
`endif
    end else begin
      r_state   <= w_state_nxt;
      r_valid   <= w_state_nxt != ST_IDLE;
      r_ascii   <= w_ascii_nxt;
      r_wr_ptr  <= r_wr_ptr + {{AW{1'b0}}, w_push};
      r_rd_ptr  <= r_rd_ptr + {{AW{1'b0}}, w_pop};
      r_level   <= r_level + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
`ifdef NEWLINE_EN
      r_grp_cnt <= w_grp_nxt;
`endif
    end
  end
endmodule

// File: tb/tb_decoder_2bit_to_ascii_tx.sv
// tb_decoder_2bit_to_ascii_tx: directed stimulus checked every cycle against a queue-based model, plus literal sequence checks.
module tb_decoder_2bit_to_ascii_tx;
  localparam int DEPTH = 4;
  localparam int GL    = 2;
  logic clk = 1'b0, rst_n, flush = 1'b0, sv = 1'b0, ar = 1'b0;
  logic [1:0] sym = 2'd0;
  logic o_sym_ready, o_ascii_valid;
  logic [6:0] o_ascii_out;
  logic [2:0] o_level;
  int errs = 0, checks = 0, acc = 0, cyc = 0;
  int got[$], gotc[$], e[$];
  int q[$];
  bit mv = 1'b0;
  int mc = 0, grp = 0;

  decoder_2bit_to_ascii_tx #(.DEPTH(DEPTH), .GROUP_LEN(GL)) dut (
    .i_clock(clk), .i_reset_n(rst_n), .i_flush(flush), .i_sym_in(sym),
    .i_sym_valid(sv), .o_sym_ready(o_sym_ready), .o_ascii_out(o_ascii_out),
    .o_ascii_valid(o_ascii_valid), .i_ascii_ready(ar), .o_level(o_level)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chkseq(string nm, int exp[$]);
    chk({nm, "_count"}, got.size(), exp.size());
    foreach (exp[i]) if (i < got.size()) chk(nm, got[i], exp[i]);
  endtask

  // Model: output slot (mv/mc) fed from a symbol queue; a line feed slot is taken once GL digits have gone out.
  initial forever begin
    bit push;
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      q.delete(); mv = 1'b0; mc = 0; grp = 0;
    end else if (flush) begin
      q.delete(); mv = 1'b0; grp = 0;
    end else begin
      push = sv && (q.size() < DEPTH);
      if (!mv || ar) begin
`ifdef NEWLINE_EN
        if (grp == GL) begin mv = 1'b1; mc = 'h0A; grp = 0; end else
`endif
        if (q.size() > 0) begin mc = 'h30 + q.pop_front(); mv = 1'b1; grp++; end
        else mv = 1'b0;
      end
      if (push) q.push_back(int'(sym));
    end
  end

  initial forever begin
    @(negedge clk);
    chk("valid", o_ascii_valid, mv);
    chk("level", o_level, q.size());
    chk("sym_ready", o_sym_ready, q.size() < DEPTH);
    if (mv) chk("ascii_out", o_ascii_out, mc);
  end

  task automatic step(bit v, logic [1:0] s, bit r, bit f = 1'b0);
    sv = v; sym = s; ar = r; flush = f;
    if (o_ascii_valid && r) begin got.push_back(int'(o_ascii_out)); gotc.push_back(cyc); end
    if (v && o_sym_ready) acc++;
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int bp[6];
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_valid", o_ascii_valid, 0);
    chk("rst_out", o_ascii_out, 'h00);
    chk("rst_level", o_level, 0);
    chk("rst_ready", o_sym_ready, 1);
    rst_n = 1'b1;
    step(0, 0, 0);
    step(1, 2, 0);
    chk("lat_n_valid", o_ascii_valid, 0);
    step(0, 0, 0);
    chk("lat_valid", o_ascii_valid, 1);
    chk("lat_out", o_ascii_out, 'h32);
    step(1, 3, 0);
    step(1, 1, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_valid", o_ascii_valid, 0);
    chk("async_level", o_level, 0);
    chk("async_ready", o_sym_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 0, 0);
    // burst
    got.delete(); gotc.delete();
    for (int i = 0; i < 4; i++) step(1, 2'(i), 1);
    repeat (4) step(0, 0, 1);
`ifdef NEWLINE_EN
    e = '{'h30, 'h31, 'h0A, 'h32, 'h33};
`else
    e = '{'h30, 'h31, 'h32, 'h33};
    if (gotc.size() == 4) chk("burst_gapless", gotc[3] - gotc[0], 3);
`endif
    chkseq("burst", e);
    // backpressure
    got.delete(); acc = 0;
    bp = '{3, 2, 1, 0, 3, 2};
    foreach (bp[i]) step(1, 2'(bp[i]), 0);
    step(0, 0, 0);
    chk("bp_accepted", acc, 5);
    chk("bp_level", o_level, 4);
    chk("bp_ready", o_sym_ready, 0);
    chk("bp_hold", o_ascii_out, 'h33);
    // full plus pop: refused this cycle, accepted the next
    acc = 0;
    step(1, 1, 1);
    chk("fp_refused", acc, 0);
    chk("fp_level", o_level, 3);
    step(1, 1, 1);
    chk("fp_accepted", acc, 1);
    chk("fp_level2", o_level, 3);
    repeat (8) step(0, 0, 1);
`ifdef NEWLINE_EN
    e = '{'h33, 'h32, 'h0A, 'h31, 'h30, 'h0A, 'h33, 'h31};
`else
    e = '{'h33, 'h32, 'h31, 'h30, 'h33, 'h31};
`endif
    chkseq("bp_drain", e);
    // flush while full
    step(0, 0, 0, 1);
    repeat (5) step(1, 0, 0);
    chk("fl_pre_level", o_level, 4);
    chk("fl_pre_valid", o_ascii_valid, 1);
    step(1, 2, 1, 1);
    chk("fl_valid", o_ascii_valid, 0);
    chk("fl_level", o_level, 0);
    got.delete();
    step(1, 2, 1);
    repeat (4) step(0, 0, 1);
    e = '{'h32};
    chkseq("flush_next", e);
    // line feed grouping
    step(0, 0, 1, 1);
    got.delete();
    step(1, 1, 1);
    step(1, 1, 1);
    step(1, 3, 1);
    repeat (5) step(0, 0, 1);
`ifdef NEWLINE_EN
    e = '{'h31, 'h31, 'h0A, 'h33};
`else
    e = '{'h31, 'h31, 'h33};
`endif
    chkseq("group", e);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
